// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (default 640x480@60).
// All outputs are registered from the same next-count, so they share one
// (X_pix, Y_pix) with zero relative skew. Reset parks the raster on the last
// pixel of a frame so the first qualified edge enters (0,0).
// Optional: define FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [9:0]  X_pix,
    output logic [9:0]  Y_pix,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

    // 11-bit bounds so a total of exactly 1024 still compares correctly
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] H_SS    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SS    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SE    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vo_q, vo_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [10:0] x_ext, y_ext;
`ifdef FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;
`endif

    // Next count, then every output decoded from that next count
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};
        hs_d  = ((x_ext >= H_SS) && (x_ext < H_SE)) ? SYNC_POL : ~SYNC_POL;
        vs_d  = ((y_ext >= V_SS) && (y_ext < V_SE)) ? SYNC_POL : ~SYNC_POL;
        vo_d  = (x_ext < H_VIS) && (y_ext < V_VIS);
        // pulses only on an advancing edge, so a held count never re-fires
        ls_d  = pix_en & (x_d == '0);
        fs_d  = ls_d & (y_d == '0);
`ifdef FRAME_COUNT_EN
        fc_d  = fs_d ? fc_q + 16'd1 : fc_q;
`endif
    end

    // State and output registers; reset = last pixel of the frame
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= H_LAST;
            y_q  <= V_LAST;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            vo_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
`ifdef FRAME_COUNT_EN
            fc_q <= '0;
`endif
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            vo_q <= vo_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
`ifdef FRAME_COUNT_EN
            fc_q <= fc_d;
`endif
        end
    end

    assign X_pix       = x_q;
    assign Y_pix       = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vo_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
`ifdef FRAME_COUNT_EN
    assign frame_cnt   = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. A default-timing instance covers reset,
// line timing and pix_en gating; a reduced-timing instance (32x19 raster,
// active-high sync) covers frame-level behaviour within a short run.
module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pix_en = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_hs, d_vs, d_vo, d_ls, d_fs;
    logic s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [24:0] d_st, s_st;
`ifdef FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    assign d_st = {d_x, d_y, d_hs, d_vs, d_vo, d_ls, d_fs};
    assign s_st = {s_x, s_y, s_hs, s_vs, s_vo, s_ls, s_fs};

    vga_timing_gen dut (
        .pixel_clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .X_pix(d_x), .Y_pix(d_y), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vo), .line_start(d_ls), .frame_start(d_fs)
`ifdef FRAME_COUNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1)
    ) dut_s (
        .pixel_clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .X_pix(s_x), .Y_pix(s_y), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vo), .line_start(s_ls), .frame_start(s_fs)
`ifdef FRAME_COUNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    task automatic test_reset();
        logic [24:0] exp;
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (5) @(negedge clk);
        exp = {10'd799, 10'd524, 5'b11000};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL reset_default got=%h exp=%h", d_st, exp); end
        exp = {10'd31, 10'd18, 5'b00000};
        n_cmp++; if (s_st !== exp) begin n_err++; $display("FAIL reset_small got=%h exp=%h", s_st, exp); end
        rst_n = 1'b1;
        @(negedge clk);
        exp = {10'd0, 10'd0, 5'b11111};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL first_edge_default got=%h exp=%h", d_st, exp); end
        exp = {10'd0, 10'd0, 5'b00111};
        n_cmp++; if (s_st !== exp) begin n_err++; $display("FAIL first_edge_small got=%h exp=%h", s_st, exp); end
    endtask

    // one full line at default timing, starting from (0,0)
    task automatic test_line();
        int hs_lo = 0, hs_first = -1, hs_last = -1;
        int vo_hi = 0, vo_first_lo = -1, ls_n = 0, ls_at = -1;
        logic [19:0] pos;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (!d_hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            if (d_vo) vo_hi++;
            else if (vo_first_lo < 0) vo_first_lo = int'(d_x);
            if (d_ls) begin ls_n++; ls_at = i; end
        end
        n_cmp++; if (hs_lo !== 96) begin n_err++; $display("FAIL hsync_width got=%0d exp=96", hs_lo); end
        n_cmp++; if (hs_first !== 656) begin n_err++; $display("FAIL hsync_first_x got=%0d exp=656", hs_first); end
        n_cmp++; if (hs_last !== 751) begin n_err++; $display("FAIL hsync_last_x got=%0d exp=751", hs_last); end
        n_cmp++; if (vo_hi !== 640) begin n_err++; $display("FAIL video_on_line_count got=%0d exp=640", vo_hi); end
        n_cmp++; if (vo_first_lo !== 640) begin n_err++; $display("FAIL video_on_end_x got=%0d exp=640", vo_first_lo); end
        n_cmp++; if (ls_n !== 1 || ls_at !== 800) begin n_err++; $display("FAIL line_start_period got n=%0d at=%0d exp n=1 at=800", ls_n, ls_at); end
        pos = {d_x, d_y};
        n_cmp++; if (pos !== {10'd0, 10'd1}) begin n_err++; $display("FAIL line_end_pos got x=%0d y=%0d exp x=0 y=1", d_x, d_y); end
    endtask

    // pix_en alternating; independent position model starting at (0,1)
    task automatic test_pix_en();
        int mx = 0, my = 1;
        int pos_bad = 0, hs_bad = 0, ls_bad = 0, ls_n = 0, wide = 0;
        int prev_i = -1, period = -1;
        logic prev_ls = 1'b0, exp_ls, exp_hs;
        for (int i = 0; i < 3200; i++) begin
            pix_en = (i % 2 == 0);
            @(negedge clk);
            if (pix_en) begin
                if (mx == 799) begin mx = 0; my = (my == 524) ? 0 : my + 1; end
                else mx = mx + 1;
            end
            exp_ls = pix_en && (mx == 0);
            exp_hs = !(mx >= 656 && mx < 752);
            if (d_x !== 10'(mx) || d_y !== 10'(my)) pos_bad++;
            if (d_hs !== exp_hs) hs_bad++;
            if (d_ls !== exp_ls) ls_bad++;
            if (d_ls) begin
                if (prev_ls) wide++;
                if (prev_i >= 0) period = i - prev_i;
                prev_i = i;
                ls_n++;
            end
            prev_ls = d_ls;
        end
        pix_en = 1'b1;
        n_cmp++; if (pos_bad !== 0) begin n_err++; $display("FAIL en_toggle_position got=%0d bad cycles exp=0", pos_bad); end
        n_cmp++; if (hs_bad !== 0) begin n_err++; $display("FAIL en_toggle_hsync got=%0d bad cycles exp=0", hs_bad); end
        n_cmp++; if (ls_bad !== 0) begin n_err++; $display("FAIL en_toggle_line_start got=%0d bad cycles exp=0", ls_bad); end
        n_cmp++; if (ls_n !== 2 || period !== 1600) begin n_err++; $display("FAIL en_toggle_line_period got n=%0d period=%0d exp n=2 period=1600", ls_n, period); end
        n_cmp++; if (wide !== 0) begin n_err++; $display("FAIL en_toggle_pulse_width got=%0d wide exp=0", wide); end
    endtask

    // two full frames on the reduced raster (32 x 19 = 608 clocks)
    task automatic test_frame();
        logic [24:0] exp;
        int vs_hi = 0, vs_bad = 0, hs_bad = 0, vo_hi = 0;
        int fs_n = 0, fs_prev = -1, fs_period = -1, ls_n = 0, fs_no_ls = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp = {10'd0, 10'd0, 5'b00111};
        n_cmp++; if (s_st !== exp) begin n_err++; $display("FAIL frame_restart got=%h exp=%h", s_st, exp); end
        for (int i = 1; i <= 1216; i++) begin
            @(negedge clk);
            if (s_vs) vs_hi++;
            if (s_vs !== (s_y == 10'd14 || s_y == 10'd15)) vs_bad++;
            if (s_hs !== (s_x >= 10'd20 && s_x < 10'd26)) hs_bad++;
            if (s_vo) vo_hi++;
            if (s_ls) ls_n++;
            if (s_fs) begin
                if (!s_ls) fs_no_ls++;
                if (fs_prev >= 0) fs_period = i - fs_prev;
                fs_prev = i;
                fs_n++;
            end
        end
        n_cmp++; if (vs_hi !== 128) begin n_err++; $display("FAIL vsync_active_clocks got=%0d exp=128", vs_hi); end
        n_cmp++; if (vs_bad !== 0) begin n_err++; $display("FAIL vsync_lines got=%0d bad cycles exp=0", vs_bad); end
        n_cmp++; if (hs_bad !== 0) begin n_err++; $display("FAIL hsync_small got=%0d bad cycles exp=0", hs_bad); end
        n_cmp++; if (vo_hi !== 384) begin n_err++; $display("FAIL video_on_frame_count got=%0d exp=384", vo_hi); end
        n_cmp++; if (fs_n !== 2 || fs_period !== 608) begin n_err++; $display("FAIL frame_start_period got n=%0d period=%0d exp n=2 period=608", fs_n, fs_period); end
        n_cmp++; if (ls_n !== 38) begin n_err++; $display("FAIL line_start_frame_count got=%0d exp=38", ls_n); end
        n_cmp++; if (fs_no_ls !== 0) begin n_err++; $display("FAIL frame_start_without_line_start got=%0d exp=0", fs_no_ls); end
    endtask

    // reduced raster at (0,0); reset mid-line while both syncs are active
    task automatic test_async_reset();
        logic [24:0] exp;
        logic [21:0] pre;
        repeat (470) @(negedge clk);
        pre = {s_x, s_y, s_hs, s_vs};
        n_cmp++; if (pre !== {10'd22, 10'd14, 2'b11}) begin n_err++; $display("FAIL pre_reset_pos got=%h exp=%h", pre, {10'd22, 10'd14, 2'b11}); end
        #2 rst_n = 1'b0;
        #1;
        exp = {10'd31, 10'd18, 5'b00000};
        n_cmp++; if (s_st !== exp) begin n_err++; $display("FAIL async_reset_small got=%h exp=%h", s_st, exp); end
        exp = {10'd799, 10'd524, 5'b11000};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL async_reset_default got=%h exp=%h", d_st, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp = {10'd0, 10'd0, 5'b00111};
        n_cmp++; if (s_st !== exp) begin n_err++; $display("FAIL async_restart_small got=%h exp=%h", s_st, exp); end
        exp = {10'd0, 10'd0, 5'b11111};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL async_restart_default got=%h exp=%h", d_st, exp); end
    endtask

`ifdef FRAME_COUNT_EN
    // reduced raster just entered (0,0) after reset: one frame counted
    task automatic test_frame_cnt();
        int found = 0;
        repeat (1216) @(negedge clk);
        n_cmp++; if (s_fc !== 16'd3) begin n_err++; $display("FAIL frame_cnt_three got=%0d exp=3", s_fc); end
        force dut_s.fc_q = 16'hFFFF;
        @(negedge clk);
        release dut_s.fc_q;
        for (int i = 0; i < 700 && found == 0; i++) begin
            @(negedge clk);
            if (s_fs) found = 1;
        end
        n_cmp++; if (found !== 1 || s_fc !== 16'd0) begin n_err++; $display("FAIL frame_cnt_wrap got found=%0d cnt=%0d exp found=1 cnt=0", found, s_fc); end
    endtask
`endif

    // pix_en low holds the parked reset count and suppresses pulses
    task automatic test_enable_gate();
        logic [24:0] exp;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp = {10'd799, 10'd524, 5'b11000};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL gate_hold_reset got=%h exp=%h", d_st, exp); end
        pix_en = 1'b1;
        @(negedge clk);
        exp = {10'd0, 10'd0, 5'b11111};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL gate_first_step got=%h exp=%h", d_st, exp); end
        pix_en = 1'b0;
        @(negedge clk);
        exp = {10'd0, 10'd0, 5'b11100};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL gate_pulse_drop got=%h exp=%h", d_st, exp); end
        pix_en = 1'b1;
        @(negedge clk);
        exp = {10'd1, 10'd0, 5'b11100};
        n_cmp++; if (d_st !== exp) begin n_err++; $display("FAIL gate_resume got=%h exp=%h", d_st, exp); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pix_en();
        test_frame();
        test_async_reset();
`ifdef FRAME_COUNT_EN
        test_frame_cnt();
`endif
        test_enable_gate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
